layer_argmax_16: RTL and testbench
==================================

LAYER_ARGMAX_16 -- requirements
Module: layer_argmax_16

Interface
REQ-001 SHALL have parameter M, default 16: number of output neurons per inference vector from the upstream layer.
REQ-002 SHALL have parameter WIDTH, default 16: signed data width of each upstream output.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port s_valid, input, 1: upstream data_in valid.
REQ-006 SHALL have port s_ready, output, 1: block accepts data_in this cycle.
REQ-007 SHALL have port data_in, input, WIDTH, signed: one neuron output per accepted beat, neuron 0 first.
REQ-008 SHALL have port m_valid, output, 1: result valid.
REQ-009 SHALL have port m_ready, input, 1: downstream accepts result.
REQ-010 SHALL have port data_out, output, WIDTH, signed: maximum value of the vector.
REQ-011 SHALL have port class_out, output, $clog2(M): index of that maximum.

Function
REQ-012 SHALL implement two states: ACCUM (s_ready=1, m_valid=0) and EMIT (s_ready=0, m_valid=1); s_ready and m_valid are registered.
REQ-013 SHALL accept a beat only when s_valid && s_ready; a beat counter (0..M-1) increments per accepted beat.
REQ-014 On the beat with counter==0, SHALL load best_val<=data_in and best_idx<=0 unconditionally.
REQ-015 On later beats, SHALL update best_val/best_idx only if data_in > best_val (signed, strict); ties keep the lower index.
REQ-016 On the accepted beat with counter==M-1, SHALL apply the REQ-015 comparison, clear the counter to 0 and enter EMIT on the next edge.
REQ-017 Latency SHALL be exactly 1 cycle: m_valid rises on the edge that captures the last beat's comparison.
REQ-018 data_out/class_out SHALL equal best_val/best_idx and SHALL be held stable while m_valid=1 and m_ready=0.
REQ-019 In EMIT, when m_ready=1, SHALL return to ACCUM on the next edge (m_valid<=0, s_ready<=1); no beat is accepted in the EMIT cycle.
REQ-020 Sustained throughput with m_ready tied high SHALL be one vector per M+1 cycles.
REQ-021 s_valid deasserted mid-vector SHALL stall the counter and hold best_val/best_idx; no timeout.
REQ-022 SHALL produce a result for any values including all-negative or all-equal vectors (all-equal -> class_out=0).
REQ-023 m_ready asserted while m_valid=0 SHALL have no effect.

Reset
REQ-024 While reset=1, SHALL set state=ACCUM, s_ready=1, m_valid=0, counter=0, best_val=0, best_idx=0, data_out=0, class_out=0.
REQ-025 Reset mid-vector or during EMIT SHALL discard the partial vector/pending result; the next accepted beat is neuron 0.
REQ-026 reset SHALL take priority over any simultaneous handshake.

Structure
REQ-027 Parameters WIDTH and M defaults and the ACCUM/EMIT state enum SHALL live in the shared layer package used by the layer blocks.
REQ-028 SHALL be a single module; no sub-module is required (comparator is inline).

Verification
REQ-029 Vector 0..15 = {5,3,9,1,0,0,0,0,0,0,0,0,0,0,0,2}, m_ready=1 -> m_valid one cycle after beat 15, data_out=9, class_out=2.
REQ-030 Tie: neurons 4 and 11 both 120, others 7 -> class_out=4, data_out=120.
REQ-031 All-negative vector, neuron 13=-3, others -50 -> class_out=13, data_out=-3; all-zero vector -> class_out=0, data_out=0.
REQ-032 m_ready low for 5 cycles after m_valid -> outputs stable, s_ready=0, no beat accepted; m_ready high -> s_ready=1 next cycle.
REQ-033 Random s_valid gaps (50%) and back-to-back vectors with m_ready=1 -> results match a reference model; gapless input gives 17 cycles per vector.
REQ-034 reset pulsed after beat 7 of a vector, then a fresh 16-beat vector {max 77 at neuron 10} -> class_out=10, data_out=77; no result emitted for the aborted vector.

Source files
------------

// File: rtl/layer_argmax_16_pkg.sv
// Shared definitions for the layer blocks.
//   LAYER_M      : default number of upstream neurons per inference vector
//   LAYER_WIDTH  : default signed data width of each neuron output
//   layer_state_e: two-state handshake FSM encoding (ACCUM / EMIT)
package layer_argmax_16_pkg;

  localparam int LAYER_M     = 16;
  localparam int LAYER_WIDTH = 16;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } layer_state_e;

endpackage : layer_argmax_16_pkg

// File: rtl/layer_argmax_16.sv
// Streaming argmax over one inference vector of M signed neuron outputs.
// Beats arrive neuron 0 first; after the last beat the running maximum
// and its index are presented on a valid/ready result interface.
//
// Ports:
//   clk       : single clock, rising-edge state updates
//   reset     : synchronous active-high reset
//   s_valid   : upstream beat valid
//   s_ready   : block accepts a beat this cycle (registered)
//   data_in   : signed neuron output
//   m_valid   : result valid (registered)
//   m_ready   : downstream accepts result
//   data_out  : maximum value of the vector
//   class_out : index of that maximum (lowest index on ties)
module layer_argmax_16
  import layer_argmax_16_pkg::*;
#(
  parameter int M     = LAYER_M,
  parameter int WIDTH = LAYER_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] data_in,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] data_out,
  output logic [$clog2(M)-1:0]    class_out
);

  localparam int IW = $clog2(M);

  layer_state_e            r_state;
  logic                    r_s_ready;
  logic                    r_m_valid;
  logic [IW-1:0]           r_cnt;
  logic signed [WIDTH-1:0] r_best_val;
  logic [IW-1:0]           r_best_idx;

  layer_state_e            w_state_nxt;
  logic                    w_s_ready_nxt;
  logic                    w_m_valid_nxt;
  logic [IW-1:0]           w_cnt_nxt;
  logic signed [WIDTH-1:0] w_best_val_nxt;
  logic [IW-1:0]           w_best_idx_nxt;
  logic                    w_accept;
  logic                    w_last;

  assign w_accept = s_valid && r_s_ready;
  assign w_last   = (r_cnt == IW'(M - 1));

  // Next-state, counter and running-maximum logic
  always_comb begin
    w_state_nxt    = r_state;
    w_s_ready_nxt  = r_s_ready;
    w_m_valid_nxt  = r_m_valid;
    w_cnt_nxt      = r_cnt;
    w_best_val_nxt = r_best_val;
    w_best_idx_nxt = r_best_idx;
    case (r_state)
      ACCUM: begin
        if (w_accept) begin
          // Neuron 0 seeds the maximum; later neurons win only on strictly
          // greater values so ties keep the lower index.
          if (r_cnt == '0) begin
            w_best_val_nxt = data_in;
            w_best_idx_nxt = '0;
          end else if (data_in > r_best_val) begin
            w_best_val_nxt = data_in;
            w_best_idx_nxt = r_cnt;
          end else begin
            w_best_val_nxt = r_best_val;
            w_best_idx_nxt = r_best_idx;
          end
          if (w_last) begin
            w_cnt_nxt     = '0;
            w_state_nxt   = EMIT;
            w_s_ready_nxt = 1'b0;
            w_m_valid_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + IW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      EMIT: begin
        if (m_ready) begin
          w_state_nxt   = ACCUM;
          w_s_ready_nxt = 1'b1;
          w_m_valid_nxt = 1'b0;
        end else begin
          w_state_nxt = EMIT;
        end
      end
      default: begin
        w_state_nxt   = ACCUM;
        w_s_ready_nxt = 1'b1;
        w_m_valid_nxt = 1'b0;
        w_cnt_nxt     = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ACCUM;
      r_s_ready  <= 1'b1;
      r_m_valid  <= 1'b0;
      r_cnt      <= '0;
      r_best_val <= '0;
      r_best_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_s_ready  <= w_s_ready_nxt;
      r_m_valid  <= w_m_valid_nxt;
      r_cnt      <= w_cnt_nxt;
      r_best_val <= w_best_val_nxt;
      r_best_idx <= w_best_idx_nxt;
    end
  end

  // Result registers are only written on accepted beats, so they are
  // naturally held while EMIT waits for m_ready.
  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign data_out  = r_best_val;
  assign class_out = r_best_idx;

endmodule : layer_argmax_16

// File: tb/tb_layer_argmax_16.sv
// Self-checking bench for layer_argmax_16: expected results are pushed to
// a scoreboard when a vector is driven and popped when the DUT emits.
module tb_layer_argmax_16;

  typedef logic signed [15:0] vec_t [16];

  logic               clk;
  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] data_in;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] data_out;
  logic [3:0]         class_out;

  int n_checks;
  int n_pass;
  int cyc;

  logic signed [15:0] exp_val_q[$];
  logic [3:0]         exp_idx_q[$];

  layer_argmax_16 #(.M(16), .WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out),
    .class_out(class_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives nbeats beats of v (optionally with random gaps); returns at the
  // negedge where the last beat is presented with s_ready high.
  task automatic drive_vec(input vec_t v, input int nbeats, input int gap_pct, input bit push);
    logic signed [15:0] bv;
    logic [3:0]         bi;
    int                 guard;
    bit                 done;
    if (push) begin
      bv = v[0];
      bi = 4'd0;
      for (int k = 1; k < 16; k++) begin
        if (v[k] > bv) begin
          bv = v[k];
          bi = 4'(k);
        end
      end
      exp_val_q.push_back(bv);
      exp_idx_q.push_back(bi);
    end
    for (int i = 0; i < nbeats; i++) begin
      guard = 0;
      done  = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
          s_valid = 1'b0;
          data_in = 16'sd0;
        end else begin
          s_valid = 1'b1;
          data_in = v[i];
          done    = s_ready;
        end
        guard++;
        if (!done && guard > 200) begin
          n_checks++;
          $display("FAIL drive_timeout beat=%0d: s_ready never 1 within 200 cycles", i);
          return;
        end
      end
    end
  endtask

  // One vector with m_ready high: latency, result and return to ACCUM.
  task automatic run_one(input vec_t v, input string name);
    logic signed [15:0] ev;
    logic [3:0]         ei;
    drive_vec(v, 16, 0, 1'b1);
    n_checks++;
    if (m_valid !== 1'b0) $display("FAIL %s_early_valid: got %b want 0", name, m_valid);
    else n_pass++;
    @(negedge clk);
    s_valid = 1'b0;
    n_checks++;
    if (m_valid !== 1'b1) $display("FAIL %s_latency: m_valid got %b want 1", name, m_valid);
    else n_pass++;
    n_checks++;
    if (s_ready !== 1'b0) $display("FAIL %s_emit_sready: got %b want 0", name, s_ready);
    else n_pass++;
    if (exp_val_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s_scoreboard: queue empty", name);
    end else begin
      ev = exp_val_q.pop_front();
      ei = exp_idx_q.pop_front();
      n_checks++;
      if (data_out !== ev) $display("FAIL %s_data: got %0d want %0d", name, data_out, ev);
      else n_pass++;
      n_checks++;
      if (class_out !== ei) $display("FAIL %s_class: got %0d want %0d", name, class_out, ei);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL %s_return: m_valid=%b s_ready=%b want 0/1", name, m_valid, s_ready);
    else n_pass++;
  endtask

  // Collects n results with m_ready high, optionally checking the spacing.
  task automatic collect(input int n, input bit chk_interval, input string name);
    int got, budget, last;
    logic signed [15:0] ev;
    logic [3:0]         ei;
    got = 0; budget = 0; last = -1;
    while (got < n && budget < n * 80) begin
      @(negedge clk);
      budget++;
      if (m_valid && m_ready) begin
        ev = exp_val_q.size() > 0 ? exp_val_q.pop_front() : 16'sd0;
        ei = exp_idx_q.size() > 0 ? exp_idx_q.pop_front() : 4'd0;
        n_checks++;
        if (data_out !== ev) $display("FAIL %s_data[%0d]: got %0d want %0d", name, got, data_out, ev);
        else n_pass++;
        n_checks++;
        if (class_out !== ei) $display("FAIL %s_class[%0d]: got %0d want %0d", name, got, class_out, ei);
        else n_pass++;
        if (chk_interval && last >= 0) begin
          n_checks++;
          if (cyc - last !== 17) $display("FAIL %s_interval[%0d]: got %0d want 17", name, got, cyc - last);
          else n_pass++;
        end
        last = cyc;
        got++;
      end
    end
    if (got < n) begin
      n_checks++;
      $display("FAIL %s_timeout: got %0d results want %0d", name, got, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; data_in = 16'sd0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b1) $display("FAIL reset_sready: got %b want 1", s_ready); else n_pass++;
    n_checks++;
    if (m_valid !== 1'b0) $display("FAIL reset_mvalid: got %b want 0", m_valid); else n_pass++;
    n_checks++;
    if (data_out !== 16'sd0) $display("FAIL reset_data: got %0d want 0", data_out); else n_pass++;
    n_checks++;
    if (class_out !== 4'd0) $display("FAIL reset_class: got %0d want 0", class_out); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = 16'sd0;
    v[0] = 16'sd5; v[1] = 16'sd3; v[2] = 16'sd9; v[3] = 16'sd1; v[15] = 16'sd2;
    run_one(v, "basic");
  endtask

  task automatic test_tie();
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = 16'sd7;
    v[4] = 16'sd120; v[11] = 16'sd120;
    run_one(v, "tie");
  endtask

  task automatic test_negative();
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = -16'sd50;
    v[13] = -16'sd3;
    run_one(v, "negative");
    for (int i = 0; i < 16; i++) v[i] = 16'sd0;
    run_one(v, "zero");
  endtask

  task automatic test_backpressure();
    vec_t v;
    logic signed [15:0] hv;
    logic [3:0]         hc;
    for (int i = 0; i < 16; i++) v[i] = 16'(i * 3 - 20);
    v[6] = 16'sd300;
    m_ready = 1'b0;
    drive_vec(v, 16, 0, 1'b1);
    @(negedge clk);
    s_valid = 1'b1;
    data_in = 16'sd100;
    n_checks++;
    if (m_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", m_valid); else n_pass++;
    hv = exp_val_q.pop_front();
    hc = exp_idx_q.pop_front();
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || data_out !== hv || class_out !== hc)
        $display("FAIL bp_hold: m_valid=%b s_ready=%b data=%0d class=%0d want 1/0/%0d/%0d",
                 m_valid, s_ready, data_out, class_out, hv, hc);
      else n_pass++;
    end
    m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL bp_release: m_valid=%b s_ready=%b want 0/1", m_valid, s_ready);
    else n_pass++;
    // A beat absorbed during the stall would misalign this vector.
    for (int i = 0; i < 16; i++) v[i] = 16'sd7;
    v[4] = 16'sd120; v[11] = 16'sd120;
    run_one(v, "bp_after");
  endtask

  task automatic test_back_to_back();
    vec_t vs [4];
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 16; i++) vs[k][i] = 16'(int'($urandom_range(40, 0)) - 20);
    m_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 4; k++) drive_vec(vs[k], 16, 0, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
      end
      collect(4, 1'b1, "b2b");
    join
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 16; i++) vs[k][i] = 16'($urandom);
    fork
      begin
        for (int k = 0; k < 4; k++) drive_vec(vs[k], 16, 50, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
      end
      collect(4, 1'b0, "gaps");
    join
  endtask

  task automatic test_reset_mid();
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = 16'sd1;
    v[3] = 16'sd500;
    drive_vec(v, 8, 0, 1'b0);
    // Reset with a beat offered at the same time: reset must win.
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b1; data_in = 16'sd900;
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || data_out !== 16'sd0)
      $display("FAIL rst_mid: m_valid=%b s_ready=%b data=%0d want 0/1/0", m_valid, s_ready, data_out);
    else n_pass++;
    reset = 1'b0; s_valid = 1'b0;
    for (int i = 0; i < 16; i++) v[i] = 16'(i);
    v[10] = 16'sd77;
    run_one(v, "rst_fresh");
    // Reset while a result is pending drops it.
    m_ready = 1'b0;
    drive_vec(v, 16, 0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ready = 1'b1;
    n_checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL rst_emit: m_valid=%b s_ready=%b want 0/1", m_valid, s_ready);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_tie();
    test_negative();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_layer_argmax_16
